// File: rtl/spi_cmd_slave_if.sv
// SPI pin and register-file signal bundle for spi_cmd_slave.
// SPI_CMD_SLAVE_RXLEN_EN adds the spi_rxlen byte count.
interface spi_cmd_slave_if;
   logic        spi_ssel_n;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_msg_end;
   logic [7:0]  spi_cmd;
   logic [63:0] spi_rxdata;
   logic [63:0] spi_txdata;
   logic        spi_txdata_valid;
`ifdef SPI_CMD_SLAVE_RXLEN_EN
   logic [3:0]  spi_rxlen;
`endif

   modport slave (
      input  spi_ssel_n, spi_sclk, spi_mosi, spi_txdata, spi_txdata_valid,
      output spi_miso, spi_msg_end, spi_cmd, spi_rxdata
`ifdef SPI_CMD_SLAVE_RXLEN_EN
      , output spi_rxlen
`endif
   );

   modport master (
      output spi_ssel_n, spi_sclk, spi_mosi, spi_txdata, spi_txdata_valid,
      input  spi_miso, spi_msg_end, spi_cmd, spi_rxdata
`ifdef SPI_CMD_SLAVE_RXLEN_EN
      , input spi_rxlen
`endif
   );
endinterface

// File: rtl/spi_cmd_slave.sv
// Oversampled SPI mode-0 command deframer: one cmd byte + up to 8 data bytes, 64-bit response on MISO.
// Optional SPI_CMD_SLAVE_RXLEN_EN adds a saturating received-byte count.
//
// state    | meaning
// IDLE     | chip select high, waiting for ssel falling edge
// CMD      | shifting in the command byte
// DATA     | shifting data bytes in, response bits out
// WAIT_END | after reset, ignore traffic until ssel is high
module spi_cmd_slave (
   input  logic          clk,
   input  logic          reset,
   spi_cmd_slave_if.slave bus
);
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CMD      = 2'd1;
   localparam logic [1:0] ST_DATA     = 2'd2;
   localparam logic [1:0] ST_WAIT_END = 2'd3;

   logic [2:0]  ssel_sync;
   logic [2:0]  sclk_sync;
   logic [1:0]  mosi_sync;
   logic [1:0]  state;
   logic [2:0]  bit_cnt;
   logic [6:0]  shift_in;
   logic [3:0]  byte_cnt;
   logic        data_rose;
   logic        load_pend;
   logic [63:0] tx_shift;
   logic        msg_end_r;
   logic [7:0]  cmd_r;
   logic [63:0] rxdata_r;

   logic        ssel_s;
   logic        mosi_s;
   logic        ssel_fall;
   logic        ssel_rise;
   logic        sclk_rise;
   logic        sclk_fall;
   logic [7:0]  byte_done;
   logic [5:0]  wr_lsb;

   assign ssel_s    = ssel_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign ssel_fall = ssel_sync[2] & ~ssel_sync[1];
   assign ssel_rise = ~ssel_sync[2] & ssel_sync[1];
   assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
   assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
   assign byte_done = {shift_in, mosi_s};
   assign wr_lsb    = {~byte_cnt[2:0], 3'b000};

   assign bus.spi_miso    = tx_shift[63];
   assign bus.spi_msg_end = msg_end_r;
   assign bus.spi_cmd     = cmd_r;
   assign bus.spi_rxdata  = rxdata_r;

`ifdef SPI_CMD_SLAVE_RXLEN_EN
   logic [3:0] rxlen_r;
   assign bus.spi_rxlen = rxlen_r;

   always_ff @(posedge clk) begin
      if (reset)
         rxlen_r <= 4'd0;
      else if (state == ST_DATA && ssel_rise)
         rxlen_r <= byte_cnt;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         // ssel sync resets low so a chip select that is already low is not seen as a new frame
         ssel_sync <= 3'b000;
         sclk_sync <= 3'b000;
         mosi_sync <= 2'b00;
         state     <= ST_WAIT_END;
         bit_cnt   <= 3'd0;
         shift_in  <= 7'd0;
         byte_cnt  <= 4'd0;
         data_rose <= 1'b0;
         load_pend <= 1'b0;
         tx_shift  <= 64'd0;
         msg_end_r <= 1'b0;
         cmd_r     <= 8'd0;
         rxdata_r  <= 64'd0;
      end else begin
         ssel_sync <= {ssel_sync[1:0], bus.spi_ssel_n};
         sclk_sync <= {sclk_sync[1:0], bus.spi_sclk};
         mosi_sync <= {mosi_sync[0], bus.spi_mosi};
         msg_end_r <= 1'b0;
         load_pend <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (ssel_fall) begin
                  rxdata_r  <= 64'd0;
                  bit_cnt   <= 3'd0;
                  byte_cnt  <= 4'd0;
                  data_rose <= 1'b0;
                  tx_shift  <= 64'd0;
                  state     <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (ssel_rise) begin
                  state <= ST_IDLE;
               end else if (sclk_rise) begin
                  shift_in <= {shift_in[5:0], mosi_s};
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     cmd_r     <= byte_done;
                     load_pend <= 1'b1;
                     state     <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (ssel_rise) begin
                  msg_end_r <= 1'b1;
                  state     <= ST_IDLE;
               end else if (sclk_rise) begin
                  data_rose <= 1'b1;
                  shift_in  <= {shift_in[5:0], mosi_s};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7 && !byte_cnt[3]) begin
                     rxdata_r[wr_lsb +: 8] <= byte_done;
                     byte_cnt              <= byte_cnt + 4'd1;
                  end
               end else if (sclk_fall && data_rose) begin
                  tx_shift <= {tx_shift[62:0], 1'b0};
               end
            end
            default: begin
               if (ssel_s)
                  state <= ST_IDLE;
            end
         endcase

         // response is captured the cycle after spi_cmd settles, giving the register file a cycle to decode
         if (load_pend)
            tx_shift <= bus.spi_txdata_valid ? bus.spi_txdata : 64'd0;
      end
   end
endmodule

// File: tb/tb_spi_cmd_slave.sv
// Self-checking bench for spi_cmd_slave: directed test-plan frames plus random frames vs a frame-level model.
module tb_spi_cmd_slave;
   localparam time HALF = 50ns;

   logic clk;
   logic reset;
   spi_cmd_slave_if bus ();

   spi_cmd_slave dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5ns clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int pulse_cnt = 0;

   logic [7:0]  fb  [16];
   logic [7:0]  got [16];
   logic [7:0]  m_cmd;
   logic [63:0] m_rx;
   logic [3:0]  m_len;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   always @(negedge clk) begin
      if (!reset && bus.spi_msg_end === 1'b1) begin
         pulse_cnt++;
         chk("pulse_cmd", {56'd0, bus.spi_cmd}, {56'd0, m_cmd});
         chk("pulse_rxdata", bus.spi_rxdata, m_rx);
`ifdef SPI_CMD_SLAVE_RXLEN_EN
         chk("pulse_rxlen", {60'd0, bus.spi_rxlen}, {60'd0, m_len});
`endif
      end
   end

   // One chip-select frame of nbits bits from fb[]; reset_at >= 0 pulses reset before that bit.
   task automatic run_frame(input int nbits, input int reset_at);
      logic [63:0] tx;
      int exp_pulses;
      int nb;
      logic expb;
      tx = bus.spi_txdata_valid ? bus.spi_txdata : 64'd0;
      if (reset_at >= 0) begin
         exp_pulses = 0;
         m_cmd = 8'd0;
         m_rx  = 64'd0;
         m_len = 4'd0;
      end else if (nbits >= 8) begin
         exp_pulses = 1;
         m_cmd = fb[0];
         nb = (nbits - 8) / 8;
         if (nb > 8) nb = 8;
         m_rx = 64'd0;
         for (int k = 0; k < nb; k++) m_rx[63-8*k -: 8] = fb[k+1];
         m_len = 4'(nb);
      end else begin
         exp_pulses = 0;
         m_rx = 64'd0;
      end
      for (int k = 0; k < 16; k++) got[k] = 8'd0;
      pulse_cnt = 0;

      bus.spi_ssel_n = 1'b0;
      repeat (6) @(posedge clk);
      #2ns;
      for (int i = 0; i < nbits; i++) begin
         if (i == reset_at) begin
            reset = 1'b1;
            repeat (3) @(posedge clk);
            #2ns reset = 1'b0;
         end
         bus.spi_mosi = fb[i/8][7 - (i % 8)];
         #HALF;
         bus.spi_sclk = 1'b1;
         if (i < 8 || (reset_at >= 0 && i >= reset_at)) expb = 1'b0;
         else if (i - 8 < 64) expb = tx[63 - (i - 8)];
         else expb = 1'b0;
         got[i/8][7 - (i % 8)] = bus.spi_miso;
         chk($sformatf("miso_bit%0d", i), {63'd0, bus.spi_miso}, {63'd0, expb});
         #HALF;
         bus.spi_sclk = 1'b0;
      end
      #HALF;
      bus.spi_ssel_n = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("pulse_count", 64'(pulse_cnt), 64'(exp_pulses));
      chk("hold_cmd", {56'd0, bus.spi_cmd}, {56'd0, m_cmd});
      chk("hold_rxdata", bus.spi_rxdata, m_rx);
`ifdef SPI_CMD_SLAVE_RXLEN_EN
      chk("hold_rxlen", {60'd0, bus.spi_rxlen}, {60'd0, m_len});
`endif
   endtask

   task automatic set_bytes(input logic [7:0] b0, input logic [7:0] start, input int n);
      fb[0] = b0;
      for (int k = 1; k < 16; k++) fb[k] = (k <= n) ? 8'(start + 8'(k - 1)) : 8'h00;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.spi_ssel_n = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.spi_txdata = 64'd0;
      bus.spi_txdata_valid = 1'b0;
      m_cmd = 8'd0; m_rx = 64'd0; m_len = 4'd0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("reset_cmd", {56'd0, bus.spi_cmd}, 64'd0);
      chk("reset_rxdata", bus.spi_rxdata, 64'd0);
      chk("reset_msg_end", {63'd0, bus.spi_msg_end}, 64'd0);
      chk("reset_miso", {63'd0, bus.spi_miso}, 64'd0);
      #2ns reset = 1'b0;
      repeat (5) @(posedge clk);
      #2ns;

      set_bytes(8'h10, 8'h01, 8);
      run_frame(72, -1);
      chk("lit_cmd_10", {56'd0, bus.spi_cmd}, 64'h10);
      chk("lit_rx_0102", bus.spi_rxdata, 64'h0102030405060708);
`ifdef SPI_CMD_SLAVE_RXLEN_EN
      chk("lit_len_8", {60'd0, bus.spi_rxlen}, 64'd8);
`endif

      set_bytes(8'h02, 8'h01, 1);
      run_frame(16, -1);
      chk("lit_rx_01", bus.spi_rxdata, 64'h0100000000000000);
      fb[0] = 8'h11; fb[1] = 8'hAB; fb[2] = 8'hCD;
      run_frame(24, -1);
      chk("lit_rx_abcd", bus.spi_rxdata, 64'hABCD000000000000);

      bus.spi_txdata = 64'hDEADBEEF00000000;
      bus.spi_txdata_valid = 1'b1;
      set_bytes(8'h20, 8'h00, 0);
      run_frame(40, -1);
      chk("lit_miso_de", {56'd0, got[1]}, 64'hDE);
      chk("lit_miso_ad", {56'd0, got[2]}, 64'hAD);
      chk("lit_miso_be", {56'd0, got[3]}, 64'hBE);
      chk("lit_miso_ef", {56'd0, got[4]}, 64'hEF);
      bus.spi_txdata_valid = 1'b0;
      run_frame(40, -1);
      chk("lit_miso_zero", {32'd0, got[1], got[2], got[3], got[4]}, 64'd0);

      set_bytes(8'hA5, 8'h00, 0);
      run_frame(5, -1);
      chk("lit_short_cmd", {56'd0, bus.spi_cmd}, 64'h20);
      set_bytes(8'h01, 8'h5A, 2);
      run_frame(20, -1);
      chk("lit_rx_12bit", bus.spi_rxdata, 64'h5A00000000000000);

      set_bytes(8'h05, 8'h30, 4);
      run_frame(40, 20);
      set_bytes(8'h01, 8'h01, 1);
      run_frame(16, -1);
      chk("lit_after_reset", {48'd0, bus.spi_cmd, bus.spi_rxdata[63:56]}, 64'h0101);

      set_bytes(8'h33, 8'h11, 10);
      run_frame(88, -1);
      chk("lit_rx_ten", bus.spi_rxdata, 64'h1112131415161718);

      for (int f = 0; f < 12; f++) begin
         for (int k = 0; k < 16; k++) fb[k] = 8'($urandom);
         bus.spi_txdata = {$urandom, $urandom};
         bus.spi_txdata_valid = 1'($urandom);
         run_frame($urandom_range(0, 88), -1);
         repeat ($urandom_range(0, 6)) @(posedge clk);
         #2ns;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
